reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Architectural register file for the 16-entry, 32-bit GPR set, plus its hold (scoreboard) bits.
- Sits directly upstream of the operand read arbitration stage and drives its r00_Q..r15_Q and hold_Q inputs.
- Issue reserves a destination register, which sets its hold bit. Execute writeback writes the data and releases the hold. Flush clears all outstanding holds.

Parameters:
- DATA_W, 32, register width.
- NREGS, 16, register count; fixed at 16, because the consumer has 16 hard-wired ports.
- RESET_VAL, 32'h0000_0000, reset contents of every register.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous active-low reset.
- rsv_valid  input  1  issue reserves a destination this cycle.
- rsv_reg  input  4  index of the reserved destination.
- wb_valid  input  1  writeback this cycle.
- wb_reg  input  4  writeback destination index.
- wb_data  input  32  writeback value.
- flush  input  1  drop all outstanding reservations.
- r00_Q..r15_Q  output  32 each  registered register contents.
- hold_Q  output  16  registered hold bits; bit n corresponds to rNN_Q.
- rsv_stall  output  1  combinational; 1 when rsv_valid targets a register that is already held.
- wb_err  output  1  sticky; set on writeback to a register that is not held.
- busy_cnt  output  5  registered population count of hold_Q, range 0..16.

Behaviour:
- Reset: applied on a clk edge with rst_n=0.
  - All rNN_Q = RESET_VAL; hold_Q = 16'h0000; wb_err = 0; busy_cnt = 0.
  - Reset overrides every other input in the same cycle, including an operation already in progress.
- Writeback: if wb_valid, then on the next edge r[wb_reg] <= wb_data and hold_Q[wb_reg] <= 0.
  - Data is visible on rNN_Q one cycle after the wb_valid cycle. There is no write-through bypass.
  - A same-cycle read from the consumer sees the old value and hold=1.
- Reservation: if rsv_valid and not rsv_stall, then hold_Q[rsv_reg] <= 1 on the next edge.
  - rsv_stall = rsv_valid & hold_Q[rsv_reg] & ~(wb_valid & wb_reg==rsv_reg).
  - While stalled, the hold bit is unchanged. The issuer holds rsv_valid and rsv_reg stable until the stall drops.
- Same-cycle reservation and writeback to the same index:
  - The data is written.
  - The hold bit ends at 1, because the new reservation wins.
  - No stall is raised and wb_err is not set.
- Same-cycle reservation and writeback to different indices: both take effect independently.
- Flush: hold_Q <= 16'h0000 on the next edge; register data is untouched.
  - A writeback in the same cycle still writes its data.
  - A reservation in the same cycle is dropped: flush wins over reservation.
- wb_err:
  - Set on the next edge when wb_valid and hold_Q[wb_reg]=0 (flush does not suppress this check).
  - The data is still written.
  - Cleared only by reset.
- busy_cnt:
  - Equals the popcount of the next-state hold vector, registered, so it always matches the current hold_Q.
  - 16 is reachable: all registers held.
- Register 0 is a normal register; it is not hard-wired to zero.
- No other state. Latency is 1 cycle for every update.

Decomposition:
- Shared package:
  - REG_IDX_W=4, NREGS=16, DATA_W=32, RESET_VAL.
  - A reg_idx_t typedef, shared with the arbitration, decode and execute stages.
- One natural sub-module: hold_scoreboard. It holds the 16-bit hold vector, the set/clear/flush priority, rsv_stall, wb_err and busy_cnt.
- The data array stays in the top module as 16 registers with write-enable decode.

Test Plan:
- Reset: wb_valid=1, wb_reg=3 with rst_n=0 -> after the edge, r03_Q=0, hold_Q=0, busy_cnt=0, wb_err=0.
- Reserve then write back: rsv r5; next cycle wb r5 = 32'hDEAD_BEEF.
  - After the first edge: hold_Q=16'h0020, busy_cnt=1.
  - After the second edge: r05_Q=32'hDEAD_BEEF, hold_Q=0.
- Re-reserve while held: reserve r7, then reserve r7 again with no writeback.
  - Second request: rsv_stall=1, hold_Q stays 16'h0080.
  - Then add wb r7 = 32'h1 in the same cycle: rsv_stall=0, r07_Q=1, hold_Q still 16'h0080.
- Collision on different indices: rsv r2 plus wb r9=32'h55 while r9 is held -> hold_Q bit2=1, bit9=0, r09_Q=32'h55.
- Flush: hold r1, r4, r15 (busy_cnt=3); assert flush together with rsv r6 -> hold_Q=0, busy_cnt=0, register data unchanged.
- Stray writeback: wb r10 = 32'h1234 with hold_Q[10]=0 -> r10_Q=32'h1234; wb_err=1 and stays 1 until reset.
- Fill all: reserve r0..r15 on consecutive cycles -> hold_Q=16'hFFFF, busy_cnt=16.

Source files
------------

// File: rtl/reg_file_scoreboard_pkg.sv
// reg_file_scoreboard_pkg: shared widths, reset value and register-index type for the GPR file
package reg_file_scoreboard_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NREGS = 16;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] RESET_VAL = 32'h0000_0000;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NREGS-1:0] reg_mask_t;
  typedef logic [REG_IDX_W:0] reg_cnt_t;
  function automatic reg_mask_t onehot(input reg_idx_t idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction
  function automatic reg_cnt_t popcount(input reg_mask_t v);
    popcount = '0;
    for (int i = 0; i < NREGS; i++) popcount += {{REG_IDX_W{1'b0}}, v[i]};
  endfunction
endpackage

// File: rtl/reg_file_scoreboard_hold_scoreboard.sv
// hold_scoreboard: per-register hold bits with reserve/release/flush priority, stall, sticky error and busy count
module hold_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rsv_valid,
  input  reg_idx_t  rsv_reg,
  input  logic      wb_valid,
  input  reg_idx_t  wb_reg,
  input  logic      flush,
  output reg_mask_t hold_q,
  output logic      rsv_stall,
  output logic      wb_err,
  output reg_cnt_t  busy_cnt
);
  reg_mask_t hold_d;
  logic      wb_err_q, wb_err_d;
  reg_cnt_t  busy_cnt_q, busy_cnt_d;
  logic      rsv_take;
  reg_mask_t hold_rel;
  // a writeback releasing the same index lets the new reservation through
  assign rsv_stall = rsv_valid & hold_q[rsv_reg] & ~(wb_valid & (wb_reg == rsv_reg));
  always_comb begin
    rsv_take = rsv_valid & ~rsv_stall;
    hold_rel = hold_q & ~(wb_valid ? onehot(wb_reg) : '0);
    hold_d = flush ? '0 : (hold_rel | (rsv_take ? onehot(rsv_reg) : '0));
    wb_err_d = wb_err_q | (wb_valid & ~hold_q[wb_reg]);
    busy_cnt_d = popcount(hold_d);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      wb_err_q <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      hold_q <= hold_d;
      wb_err_q <= wb_err_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
  assign wb_err = wb_err_q;
  assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 16x32 architectural register file with hold scoreboard feeding operand arbitration
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rsv_valid,
  input  logic [3:0]        rsv_reg,
  input  logic              wb_valid,
  input  logic [3:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [DATA_W-1:0] r00_Q,
  output logic [DATA_W-1:0] r01_Q,
  output logic [DATA_W-1:0] r02_Q,
  output logic [DATA_W-1:0] r03_Q,
  output logic [DATA_W-1:0] r04_Q,
  output logic [DATA_W-1:0] r05_Q,
  output logic [DATA_W-1:0] r06_Q,
  output logic [DATA_W-1:0] r07_Q,
  output logic [DATA_W-1:0] r08_Q,
  output logic [DATA_W-1:0] r09_Q,
  output logic [DATA_W-1:0] r10_Q,
  output logic [DATA_W-1:0] r11_Q,
  output logic [DATA_W-1:0] r12_Q,
  output logic [DATA_W-1:0] r13_Q,
  output logic [DATA_W-1:0] r14_Q,
  output logic [DATA_W-1:0] r15_Q,
  output logic [NREGS-1:0]  hold_Q,
  output logic              rsv_stall,
  output logic              wb_err,
  output logic [4:0]        busy_cnt
);
  data_t regs_q [NREGS];
  data_t regs_d [NREGS];
  hold_scoreboard u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_valid(rsv_valid),
    .rsv_reg  (rsv_reg),
    .wb_valid (wb_valid),
    .wb_reg   (wb_reg),
    .flush    (flush),
    .hold_q   (hold_Q),
    .rsv_stall(rsv_stall),
    .wb_err   (wb_err),
    .busy_cnt (busy_cnt)
  );
  // writeback lands unconditionally; holds and errors are the scoreboard's business
  always_comb begin
    for (int i = 0; i < NREGS; i++)
      regs_d[i] = (wb_valid && wb_reg == reg_idx_t'(i)) ? wb_data : regs_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++)
      regs_q[i] <= !rst_n ? RESET_VAL : regs_d[i];
  end
  assign r00_Q = regs_q[0];
  assign r01_Q = regs_q[1];
  assign r02_Q = regs_q[2];
  assign r03_Q = regs_q[3];
  assign r04_Q = regs_q[4];
  assign r05_Q = regs_q[5];
  assign r06_Q = regs_q[6];
  assign r07_Q = regs_q[7];
  assign r08_Q = regs_q[8];
  assign r09_Q = regs_q[9];
  assign r10_Q = regs_q[10];
  assign r11_Q = regs_q[11];
  assign r12_Q = regs_q[12];
  assign r13_Q = regs_q[13];
  assign r14_Q = regs_q[14];
  assign r15_Q = regs_q[15];
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed plan plus random traffic checked every cycle against a behavioural model
module tb_reg_file_scoreboard;
  logic clk = 1'b0;
  logic rst_n, rsv_valid, wb_valid, flush;
  logic [3:0] rsv_reg, wb_reg;
  logic [31:0] wb_data;
  logic [31:0] r_dut [16];
  logic [15:0] hold_Q;
  logic rsv_stall, wb_err;
  logic [4:0] busy_cnt;
  int checks = 0, errors = 0;
  logic [31:0] m_regs [16];
  bit m_held [16];
  bit m_err;
  bit model_valid = 0;
  always #5 clk = ~clk;
  reg_file_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .r00_Q(r_dut[0]), .r01_Q(r_dut[1]), .r02_Q(r_dut[2]), .r03_Q(r_dut[3]),
    .r04_Q(r_dut[4]), .r05_Q(r_dut[5]), .r06_Q(r_dut[6]), .r07_Q(r_dut[7]),
    .r08_Q(r_dut[8]), .r09_Q(r_dut[9]), .r10_Q(r_dut[10]), .r11_Q(r_dut[11]),
    .r12_Q(r_dut[12]), .r13_Q(r_dut[13]), .r14_Q(r_dut[14]), .r15_Q(r_dut[15]),
    .hold_Q(hold_Q), .rsv_stall(rsv_stall), .wb_err(wb_err), .busy_cnt(busy_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] model_hold();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) if (m_held[i]) v = v | (16'd1 << i);
    return v;
  endfunction
  function automatic int model_busy();
    int n = 0;
    foreach (m_held[i]) n += int'(m_held[i]);
    return n;
  endfunction
  function automatic bit model_stall();
    return rsv_valid && m_held[rsv_reg] && !(wb_valid && wb_reg == rsv_reg);
  endfunction
  always @(posedge clk) begin
    bit take;
    if (!rst_n) begin
      foreach (m_regs[i]) begin m_regs[i] = 32'h0; m_held[i] = 0; end
      m_err = 0;
    end else begin
      take = rsv_valid && !model_stall();
      if (wb_valid) begin
        if (!m_held[wb_reg]) m_err = 1;
        m_regs[wb_reg] = wb_data;
        m_held[wb_reg] = 0;
      end
      if (flush) foreach (m_held[i]) m_held[i] = 0;
      else if (take) m_held[rsv_reg] = 1;
    end
    model_valid = 1;
  end
  always @(negedge clk) if (model_valid) begin
    for (int i = 0; i < 16; i++) chk($sformatf("model r%0d", i), r_dut[i], m_regs[i]);
    chk("model hold", 32'(hold_Q), 32'(model_hold()));
    chk("model busy", 32'(busy_cnt), 32'(model_busy()));
    chk("model wb_err", 32'(wb_err), 32'(m_err));
    chk("model rsv_stall", 32'(rsv_stall), 32'(model_stall()));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rsv_valid = 0; wb_valid = 0; flush = 0;
  endtask
  task automatic rsv(input int r);
    idle(); rsv_valid = 1; rsv_reg = 4'(r); tick();
  endtask
  initial begin
    rst_n = 0; idle(); rsv_reg = 0;
    wb_valid = 1; wb_reg = 3; wb_data = 32'hFFFF_FFFF;
    tick();
    chk("reset r03", r_dut[3], 32'h0);
    chk("reset hold", 32'(hold_Q), 32'h0);
    chk("reset busy", 32'(busy_cnt), 32'h0);
    chk("reset wb_err", 32'(wb_err), 32'h0);
    rst_n = 1; idle(); tick();
    rsv(5);
    chk("rsv5 hold", 32'(hold_Q), 32'h0020);
    chk("rsv5 busy", 32'(busy_cnt), 32'd1);
    idle(); wb_valid = 1; wb_reg = 5; wb_data = 32'hDEAD_BEEF; tick();
    chk("wb5 r05", r_dut[5], 32'hDEAD_BEEF);
    chk("wb5 hold", 32'(hold_Q), 32'h0);
    rsv(7);
    #1 chk("re-rsv7 stall", 32'(rsv_stall), 32'd1);
    tick();
    chk("re-rsv7 hold", 32'(hold_Q), 32'h0080);
    wb_valid = 1; wb_reg = 7; wb_data = 32'h1;
    #1 chk("rsv+wb7 stall", 32'(rsv_stall), 32'd0);
    tick();
    chk("rsv+wb7 r07", r_dut[7], 32'h1);
    chk("rsv+wb7 hold", 32'(hold_Q), 32'h0080);
    chk("rsv+wb7 wb_err", 32'(wb_err), 32'd0);
    rsv(9);
    idle(); rsv_valid = 1; rsv_reg = 2; wb_valid = 1; wb_reg = 9; wb_data = 32'h55; tick();
    chk("diff hold", 32'(hold_Q), 32'h0084);
    chk("diff r09", r_dut[9], 32'h55);
    idle(); flush = 1; tick();
    rsv(1); rsv(4); rsv(15);
    chk("pre-flush hold", 32'(hold_Q), 32'h8012);
    chk("pre-flush busy", 32'(busy_cnt), 32'd3);
    idle(); flush = 1; rsv_valid = 1; rsv_reg = 6; tick();
    chk("flush hold", 32'(hold_Q), 32'h0);
    chk("flush busy", 32'(busy_cnt), 32'd0);
    chk("flush r05", r_dut[5], 32'hDEAD_BEEF);
    chk("flush r09", r_dut[9], 32'h55);
    idle(); wb_valid = 1; wb_reg = 10; wb_data = 32'h1234; tick();
    chk("stray r10", r_dut[10], 32'h1234);
    chk("stray wb_err", 32'(wb_err), 32'd1);
    idle(); tick(); tick();
    chk("sticky wb_err", 32'(wb_err), 32'd1);
    for (int i = 0; i < 16; i++) rsv(i);
    chk("fill hold", 32'(hold_Q), 32'hFFFF);
    chk("fill busy", 32'(busy_cnt), 32'd16);
    idle(); rst_n = 0; tick();
    chk("reset2 wb_err", 32'(wb_err), 32'd0);
    chk("reset2 r10", r_dut[10], 32'h0);
    rst_n = 1;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_reg = 4'($urandom_range(0, 15));
      wb_valid = ($urandom_range(0, 2) != 0);
      wb_reg = ($urandom_range(0, 1) == 1) ? rsv_reg : 4'($urandom_range(0, 15));
      wb_data = $urandom;
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle(); rst_n = 1; tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
